// File: rtl/signal_conflict_monitor.sv
// -----------------------------------------------------------------------------
// signal_conflict_monitor
//
// Watches the four approach light codes coming from the phase controller and
// stands between them and the lamp drivers. A conflict is two or more
// approaches showing green/yellow at once, or any approach showing a code that
// is not one of green (3'b100), yellow (3'b101) or red (3'b010). Short glitches
// are filtered. A conflict that persists for FILT_CYC consecutive cycles
// latches a fault: every approach then flashes red until an operator clear is
// accepted while the inputs are clean. After the clear, all approaches show
// solid red for HOLD_CYC cycles before normal pass-through resumes.
//
// Parameters
//   FILT_CYC   : consecutive conflict cycles needed to latch a fault (1..15)
//   FLASH_HALF : cycles per half-period of the fault flash (1..255)
//   HOLD_CYC   : cycles of solid all-red after a fault is cleared (1..255)
//
// Ports
//   clk        in   1  clock
//   rst_a      in   1  asynchronous active-high reset
//   e_lights   in   3  approach e light code
//   f_lights   in   3  approach f light code
//   z_lights   in   3  approach z light code
//   w_lights   in   3  approach w light code
//   fault_clr  in   1  operator clear request (level-sampled)
//   lamp_r     out  4  red lamp drives    (bit0 e, bit1 f, bit2 z, bit3 w)
//   lamp_y     out  4  yellow lamp drives (same bit order)
//   lamp_g     out  4  green lamp drives  (same bit order)
//   fault      out  1  high while flashing or in the post-clear hold
//   fault_code out  2  latched cause: 01 multiple non-red, 10 invalid, 11 both
// -----------------------------------------------------------------------------
module signal_conflict_monitor #(
    parameter int FILT_CYC   = 4,
    parameter int FLASH_HALF = 8,
    parameter int HOLD_CYC   = 6
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [2:0] e_lights,
    input  logic [2:0] f_lights,
    input  logic [2:0] z_lights,
    input  logic [2:0] w_lights,
    input  logic       fault_clr,
    output logic [3:0] lamp_r,
    output logic [3:0] lamp_y,
    output logic [3:0] lamp_g,
    output logic       fault,
    output logic [1:0] fault_code
);

    // Light codes as driven by the phase controller.
    localparam logic [2:0] CODE_GREEN  = 3'b100;
    localparam logic [2:0] CODE_YELLOW = 3'b101;
    localparam logic [2:0] CODE_RED    = 3'b010;

    localparam logic [3:0] ALL_ON  = 4'b1111;
    localparam logic [3:0] ALL_OFF = 4'b0000;

    // Terminal counts; each counter reloads at its terminal value, so none can
    // run past its parameter bound.
    localparam logic [3:0] FILT_LAST  = 4'(FILT_CYC - 1);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_HALF - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FILTER = 2'd1,
        ST_FAULT  = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Per-approach helpers
    // -------------------------------------------------------------------------

    // Lamp decode returned as {red, yellow, green}. Anything that is not a
    // recognised code falls back to red, so an approach can never light more
    // than one lamp and a corrupt code never shows a proceed aspect.
    function automatic logic [2:0] decode_lamp(input logic [2:0] code);
        logic [2:0] ryg;
        case (code)
            CODE_GREEN:  ryg = 3'b001;
            CODE_YELLOW: ryg = 3'b010;
            CODE_RED:    ryg = 3'b100;
            default:     ryg = 3'b100;
        endcase
        return ryg;
    endfunction

    // Green or yellow: the approach has (or is about to lose) right of way.
    function automatic logic is_go(input logic [2:0] code);
        return (code == CODE_GREEN) || (code == CODE_YELLOW);
    endfunction

    // Not one of the three legal codes.
    function automatic logic is_invalid(input logic [2:0] code);
        return (code != CODE_GREEN) && (code != CODE_YELLOW) && (code != CODE_RED);
    endfunction

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [3:0][2:0] codes_s;
    logic [2:0]      go_cnt_s;
    logic            invalid_any_s;
    logic            multi_go_s;
    logic            conflict_s;
    logic [1:0]      cause_s;
    logic [3:0]      dec_r_s;
    logic [3:0]      dec_y_s;
    logic [3:0]      dec_g_s;
    logic            enter_fault_s;

    state_t          state_r;
    logic [3:0]      filt_cnt_r;
    logic [7:0]      flash_cnt_r;
    logic [7:0]      hold_cnt_r;
    logic            flash_on_r;

    // Pack approaches so index i matches lamp bit i (e, f, z, w).
    assign codes_s = {w_lights, z_lights, f_lights, e_lights};

    // Classify the current inputs: go count, invalid flag, lamp decode.
    always_comb begin
        go_cnt_s      = 3'd0;
        invalid_any_s = 1'b0;
        dec_r_s       = 4'b0000;
        dec_y_s       = 4'b0000;
        dec_g_s       = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            go_cnt_s      = go_cnt_s + {2'b00, is_go(codes_s[i])};
            invalid_any_s = invalid_any_s | is_invalid(codes_s[i]);
            {dec_r_s[i], dec_y_s[i], dec_g_s[i]} = decode_lamp(codes_s[i]);
        end
        multi_go_s = (go_cnt_s > 3'd1);
        conflict_s = multi_go_s | invalid_any_s;
        cause_s    = {invalid_any_s, multi_go_s};
    end

    // Decide whether this edge starts (or restarts) a fault. HOLD goes
    // straight back to FAULT on any conflict; it never re-enters the filter.
    always_comb begin
        enter_fault_s = 1'b0;
        case (state_r)
            ST_RUN:    enter_fault_s = conflict_s && (FILT_CYC == 1);
            ST_FILTER: enter_fault_s = conflict_s && (filt_cnt_r == FILT_LAST);
            ST_HOLD:   enter_fault_s = conflict_s;
            ST_FAULT:  enter_fault_s = 1'b0;
            default:   enter_fault_s = 1'b0;
        endcase
    end

    // Monitor FSM with registered lamp, fault and cause outputs.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_r     <= ST_RUN;
            filt_cnt_r  <= 4'd0;
            flash_cnt_r <= 8'd0;
            hold_cnt_r  <= 8'd0;
            flash_on_r  <= 1'b1;
            lamp_r      <= ALL_ON;
            lamp_y      <= ALL_OFF;
            lamp_g      <= ALL_OFF;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
        end else if (enter_fault_s) begin
            // Fresh fault: latch cause from this cycle, flash starts in the on phase.
            state_r     <= ST_FAULT;
            filt_cnt_r  <= 4'd0;
            flash_cnt_r <= 8'd0;
            hold_cnt_r  <= 8'd0;
            flash_on_r  <= 1'b1;
            lamp_r      <= ALL_ON;
            lamp_y      <= ALL_OFF;
            lamp_g      <= ALL_OFF;
            fault       <= 1'b1;
            fault_code  <= cause_s;
        end else begin
            case (state_r)
                ST_RUN: begin
                    lamp_r <= dec_r_s;
                    lamp_y <= dec_y_s;
                    lamp_g <= dec_g_s;
                    if (conflict_s) begin
                        // This edge is the first conflict cycle of the run.
                        state_r    <= ST_FILTER;
                        filt_cnt_r <= 4'd1;
                    end else begin
                        state_r    <= ST_RUN;
                        filt_cnt_r <= 4'd0;
                    end
                end

                ST_FILTER: begin
                    // Still passing the (possibly conflicting) inputs through
                    // while the glitch filter decides.
                    lamp_r <= dec_r_s;
                    lamp_y <= dec_y_s;
                    lamp_g <= dec_g_s;
                    if (conflict_s) begin
                        state_r    <= ST_FILTER;
                        filt_cnt_r <= filt_cnt_r + 4'd1;
                    end else begin
                        state_r    <= ST_RUN;
                        filt_cnt_r <= 4'd0;
                    end
                end

                ST_FAULT: begin
                    lamp_y <= ALL_OFF;
                    lamp_g <= ALL_OFF;
                    if (fault_clr && !conflict_s) begin
                        // Clear accepted only against clean inputs.
                        state_r     <= ST_HOLD;
                        hold_cnt_r  <= 8'd0;
                        flash_cnt_r <= 8'd0;
                        flash_on_r  <= 1'b1;
                        lamp_r      <= ALL_ON;
                    end else if (flash_cnt_r == FLASH_LAST) begin
                        // Half-period elapsed: flip the flash phase.
                        state_r     <= ST_FAULT;
                        flash_cnt_r <= 8'd0;
                        flash_on_r  <= ~flash_on_r;
                        lamp_r      <= flash_on_r ? ALL_OFF : ALL_ON;
                    end else begin
                        state_r     <= ST_FAULT;
                        flash_cnt_r <= flash_cnt_r + 8'd1;
                    end
                end

                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        // Hold complete: release the fault and resume pass-through.
                        state_r    <= ST_RUN;
                        hold_cnt_r <= 8'd0;
                        lamp_r     <= dec_r_s;
                        lamp_y     <= dec_y_s;
                        lamp_g     <= dec_g_s;
                        fault      <= 1'b0;
                        fault_code <= 2'b00;
                    end else begin
                        state_r    <= ST_HOLD;
                        hold_cnt_r <= hold_cnt_r + 8'd1;
                        lamp_r     <= ALL_ON;
                        lamp_y     <= ALL_OFF;
                        lamp_g     <= ALL_OFF;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to the reset picture.
                    state_r     <= ST_RUN;
                    filt_cnt_r  <= 4'd0;
                    flash_cnt_r <= 8'd0;
                    hold_cnt_r  <= 8'd0;
                    flash_on_r  <= 1'b1;
                    lamp_r      <= ALL_ON;
                    lamp_y      <= ALL_OFF;
                    lamp_g      <= ALL_OFF;
                    fault       <= 1'b0;
                    fault_code  <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// -----------------------------------------------------------------------------
// tb_signal_conflict_monitor
//
// Directed scenarios followed by bursty random stimulus. Expected outputs come
// from a reference model that tracks conflict run length, time since fault
// entry and time since clear, and derives the lamp picture arithmetically.
// -----------------------------------------------------------------------------
module tb_signal_conflict_monitor;

    localparam int FILT_CYC   = 4;
    localparam int FLASH_HALF = 8;
    localparam int HOLD_CYC   = 6;

    localparam logic [2:0] GRN = 3'b100;
    localparam logic [2:0] YEL = 3'b101;
    localparam logic [2:0] RED = 3'b010;
    localparam logic [2:0] BAD = 3'b111;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic [2:0] e_lights = 3'b010;
    logic [2:0] f_lights = 3'b010;
    logic [2:0] z_lights = 3'b010;
    logic [2:0] w_lights = 3'b010;
    logic       fault_clr = 1'b0;
    logic [3:0] lamp_r;
    logic [3:0] lamp_y;
    logic [3:0] lamp_g;
    logic       fault;
    logic [1:0] fault_code;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit         m_flashing;
    bit         m_holding;
    int         m_run_len;
    int         m_fault_age;
    int         m_hold_age;
    logic [1:0] m_code;

    always #5 clk = ~clk;

    signal_conflict_monitor #(
        .FILT_CYC  (FILT_CYC),
        .FLASH_HALF(FLASH_HALF),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .e_lights  (e_lights),
        .f_lights  (f_lights),
        .z_lights  (z_lights),
        .w_lights  (w_lights),
        .fault_clr (fault_clr),
        .lamp_r    (lamp_r),
        .lamp_y    (lamp_y),
        .lamp_g    (lamp_g),
        .fault     (fault),
        .fault_code(fault_code)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Mask of approaches whose code equals pat.
    function automatic logic [3:0] match_mask(input logic [2:0] pat);
        logic [3:0] m;
        m[0] = (e_lights == pat);
        m[1] = (f_lights == pat);
        m[2] = (z_lights == pat);
        m[3] = (w_lights == pat);
        return m;
    endfunction

    // Cause bits of the present inputs: {any invalid, more than one go}.
    function automatic logic [1:0] cause_now();
        logic [3:0] go_m;
        logic [3:0] inv_m;
        int         go_n;
        go_m  = match_mask(GRN) | match_mask(YEL);
        inv_m = ~(go_m | match_mask(RED));
        go_n  = $countones(go_m);
        return {(inv_m != 4'b0000), (go_n > 1)};
    endfunction

    task automatic model_reset();
        m_flashing  = 1'b0;
        m_holding   = 1'b0;
        m_run_len   = 0;
        m_fault_age = 0;
        m_hold_age  = 0;
        m_code      = 2'b00;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [1:0] c;
        bit         conf;
        c    = cause_now();
        conf = (c != 2'b00);
        if (m_flashing) begin
            if (fault_clr && !conf) begin
                m_flashing = 1'b0;
                m_holding  = 1'b1;
                m_hold_age = 0;
            end else begin
                m_fault_age++;
            end
        end else if (m_holding) begin
            if (conf) begin
                m_holding   = 1'b0;
                m_flashing  = 1'b1;
                m_fault_age = 0;
                m_code      = c;
            end else begin
                m_hold_age++;
                if (m_hold_age >= HOLD_CYC) begin
                    m_holding = 1'b0;
                    m_code    = 2'b00;
                    m_run_len = 0;
                end
            end
        end else begin
            if (conf) begin
                m_run_len++;
                if (m_run_len >= FILT_CYC) begin
                    m_flashing  = 1'b1;
                    m_fault_age = 0;
                    m_code      = c;
                    m_run_len   = 0;
                end
            end else begin
                m_run_len = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] er, ey, eg;
        logic [3:0] go_m;
        if (m_flashing) begin
            er = (((m_fault_age / FLASH_HALF) % 2) == 0) ? 4'b1111 : 4'b0000;
            ey = 4'b0000;
            eg = 4'b0000;
        end else if (m_holding) begin
            er = 4'b1111;
            ey = 4'b0000;
            eg = 4'b0000;
        end else begin
            go_m = match_mask(GRN) | match_mask(YEL);
            eg = match_mask(GRN);
            ey = match_mask(YEL);
            er = ~go_m;
        end
        chk({tag, ".lamp_r"}, lamp_r, er);
        chk({tag, ".lamp_y"}, lamp_y, ey);
        chk({tag, ".lamp_g"}, lamp_g, eg);
        chk({tag, ".fault"}, {3'b000, fault}, {3'b000, (m_flashing || m_holding)});
        chk({tag, ".fault_code"}, {2'b00, fault_code}, {2'b00, m_code});
        for (int i = 0; i < 4; i++) begin
            int n;
            n = int'(lamp_r[i]) + int'(lamp_y[i]) + int'(lamp_g[i]);
            chk({tag, ".one_lamp"}, {3'b000, (n <= 1)}, 4'b0001);
        end
    endtask

    task automatic set_in(input logic [2:0] e, input logic [2:0] f,
                          input logic [2:0] z, input logic [2:0] w, input logic clr);
        e_lights  = e;
        f_lights  = f;
        z_lights  = z;
        w_lights  = w;
        fault_clr = clr;
    endtask

    // One clock: model advances at the edge, outputs checked 1 time unit later.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic rand_pattern();
        logic [2:0] v [4];
        int k;
        for (int i = 0; i < 4; i++) v[i] = RED;
        k = $urandom_range(0, 99);
        if (k < 50) begin
            v[$urandom_range(0, 3)] = ($urandom_range(0, 1) == 1) ? GRN : YEL;
        end else if (k < 62) begin
            // all red
        end else if (k < 88) begin
            v[$urandom_range(0, 3)] = ($urandom_range(0, 1) == 1) ? GRN : YEL;
            v[$urandom_range(0, 3)] = ($urandom_range(0, 1) == 1) ? GRN : YEL;
        end else begin
            v[$urandom_range(0, 3)] = 3'($urandom_range(0, 7));
        end
        e_lights = v[0];
        f_lights = v[1];
        z_lights = v[2];
        w_lights = v[3];
    endtask

    initial begin
        model_reset();

        // Reset picture while rst_a is held through a clock edge.
        #12;
        chk("reset.lamp_r", lamp_r, 4'b1111);
        chk("reset.lamp_y", lamp_y, 4'b0000);
        chk("reset.lamp_g", lamp_g, 4'b0000);
        chk("reset.fault", {3'b000, fault}, 4'b0000);
        chk("reset.fault_code", {2'b00, fault_code}, 4'b0000);
        #1 rst_a = 1'b0;

        // Normal RUN: e green, others red.
        set_in(GRN, RED, RED, RED, 1'b0);
        cyc("run");
        chk("run.g_const", lamp_g, 4'b0001);
        chk("run.r_const", lamp_r, 4'b1110);
        chk("run.y_const", lamp_y, 4'b0000);

        // Glitch: e = f = green for 3 cycles, then f red.
        set_in(GRN, GRN, RED, RED, 1'b0);
        for (int i = 0; i < 3; i++) cyc("glitch_on");
        chk("glitch.dual_green", lamp_g, 4'b0011);
        set_in(GRN, RED, RED, RED, 1'b0);
        for (int i = 0; i < 3; i++) cyc("glitch_off");
        chk("glitch.no_fault", {3'b000, fault}, 4'b0000);

        // Persistent conflict: e green, z yellow.
        set_in(GRN, RED, YEL, RED, 1'b0);
        for (int i = 0; i < 3; i++) cyc("persist_filter");
        chk("persist.pre_fault", {3'b000, fault}, 4'b0000);
        cyc("persist_enter");
        chk("persist.fault", {3'b000, fault}, 4'b0001);
        chk("persist.code", {2'b00, fault_code}, 4'b0001);
        for (int i = 0; i < 20; i++) cyc("persist_flash");

        // Clear refused while the conflict is still present.
        fault_clr = 1'b1;
        for (int i = 0; i < 3; i++) cyc("clr_refused");
        chk("clr_refused.fault", {3'b000, fault}, 4'b0001);

        // Clean inputs with clear: hold for HOLD_CYC cycles then RUN.
        set_in(RED, RED, RED, RED, 1'b1);
        cyc("clr_accept");
        fault_clr = 1'b0;
        for (int i = 0; i < HOLD_CYC - 1; i++) cyc("hold");
        chk("hold.last_red", lamp_r, 4'b1111);
        cyc("hold_exit");
        chk("hold_exit.fault", {3'b000, fault}, 4'b0000);
        chk("hold_exit.code", {2'b00, fault_code}, 4'b0000);

        // Invalid code on w for 4 cycles latches cause 10.
        set_in(RED, RED, RED, BAD, 1'b0);
        for (int i = 0; i < 4; i++) cyc("invalid");
        chk("invalid.code", {2'b00, fault_code}, 4'b0010);
        set_in(GRN, GRN, RED, BAD, 1'b0);
        for (int i = 0; i < 3; i++) cyc("invalid_latched");
        chk("invalid.code_held", {2'b00, fault_code}, 4'b0010);

        // Move into the flash-off phase, then pulse reset between edges.
        for (int i = 0; i < 7; i++) cyc("to_flash_off");
        chk("flash_off.lamp_r", lamp_r, 4'b0000);
        #2 rst_a = 1'b1;
        #1;
        chk("midreset.lamp_r", lamp_r, 4'b1111);
        chk("midreset.fault", {3'b000, fault}, 4'b0000);
        chk("midreset.code", {2'b00, fault_code}, 4'b0000);
        #3 rst_a = 1'b0;
        model_reset();
        set_in(YEL, RED, RED, RED, 1'b0);
        cyc("post_reset");
        chk("post_reset.y", lamp_y, 4'b0001);

        // Conflict during HOLD restarts FAULT directly with the new cause.
        set_in(RED, RED, RED, BAD, 1'b0);
        for (int i = 0; i < 4; i++) cyc("restart_fault");
        set_in(RED, RED, RED, RED, 1'b1);
        cyc("restart_clr");
        fault_clr = 1'b0;
        for (int i = 0; i < 2; i++) cyc("restart_hold");
        set_in(GRN, GRN, RED, RED, 1'b0);
        cyc("restart_hit");
        chk("restart.code", {2'b00, fault_code}, 4'b0001);
        chk("restart.flash_on", lamp_r, 4'b1111);
        for (int i = 0; i < 3; i++) cyc("restart_flash");
        set_in(RED, RED, RED, RED, 1'b1);
        for (int i = 0; i < HOLD_CYC + 2; i++) cyc("restart_recover");
        fault_clr = 1'b0;

        // Bursty random stimulus: each pattern held for a few cycles.
        for (int b = 0; b < 250; b++) begin
            int len;
            rand_pattern();
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                fault_clr = ($urandom_range(0, 2) == 0);
                cyc("random");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
